// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache-to-memory arbiter and its burst adaptor.
package cache_mem_pkg;

    localparam int LINE_WIDTH_DEF = 256;
    localparam int BEAT_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int BEATS          = LINE_WIDTH_DEF / BEAT_WIDTH_DEF;
    localparam int OFFSET_BITS    = 5;
    localparam int CNT_WIDTH      = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_t;

    // On a tie the side that was not served last wins.
    function automatic owner_t pick_winner(input logic i_req, input logic d_req,
                                           input owner_t last_grant);
        owner_t w;
        if (i_req && d_req) begin
            w = (last_grant == ICACHE) ? DCACHE : ICACHE;
        end else if (d_req) begin
            w = DCACHE;
        end else begin
            w = ICACHE;
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_checker.sv
// Protocol checks on the cache side and the grant/response outputs of the arbiter.
module cache_mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic dcache_pmem_read,
    input logic dcache_pmem_write,
    input logic grant_i,
    input logic grant_d,
    input logic icache_pmem_resp,
    input logic dcache_pmem_resp
);

    // A simultaneous dcache read and write is illegal; the arbiter serves it as a write.
    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(dcache_pmem_read && dcache_pmem_write));

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(grant_i && grant_d));

    a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(icache_pmem_resp && dcache_pmem_resp));

endmodule

// File: rtl/line_burst_adaptor.sv
// Serialises one cache line into memory beats: beat counter, read-line assembly,
// write-beat selection and the end-of-burst pulse.
module line_burst_adaptor
    import cache_mem_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  start_write,
    input  logic [LINE_WIDTH-1:0] start_line,
    input  logic                  active,
    input  logic                  mem_resp,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    output logic [LINE_WIDTH-1:0] line_next,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    output logic                  burst_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  write_r;
    logic [LINE_WIDTH-1:0] line_r;
    logic                  beat_s;
    logic [BEAT_WIDTH-1:0] wbeat_nxt_s;

    assign beat_s     = active && mem_resp;
    assign burst_done = beat_s && (cnt_r == LAST_BEAT);

    // Line as it will look after this cycle's read beat lands.
    always_comb begin
        line_next = line_r;
        if (beat_s && !write_r) begin
            line_next[BEAT_WIDTH*int'(cnt_r) +: BEAT_WIDTH] = mem_rdata;
        end else begin
            line_next = line_r;
        end
    end

    // Next write beat to present once the current one is accepted.
    always_comb begin
        wbeat_nxt_s = {BEAT_WIDTH{1'b0}};
        if (cnt_r == LAST_BEAT) begin
            wbeat_nxt_s = {BEAT_WIDTH{1'b0}};
        end else begin
            wbeat_nxt_s = line_r[BEAT_WIDTH*(int'(cnt_r) + 1) +: BEAT_WIDTH];
        end
    end

    // Counter, line buffer and write-beat register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CNT_WIDTH{1'b0}};
            write_r   <= 1'b0;
            line_r    <= {LINE_WIDTH{1'b0}};
            mem_wdata <= {BEAT_WIDTH{1'b0}};
        end else if (start) begin
            cnt_r     <= {CNT_WIDTH{1'b0}};
            write_r   <= start_write;
            line_r    <= start_write ? start_line : {LINE_WIDTH{1'b0}};
            mem_wdata <= start_write ? start_line[BEAT_WIDTH-1:0] : {BEAT_WIDTH{1'b0}};
        end else if (beat_s) begin
            cnt_r     <= cnt_r + CNT_ONE;
            line_r    <= line_next;
            mem_wdata <= write_r ? wbeat_nxt_s : {BEAT_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port and returns
// assembled lines with a one-cycle completion pulse to the granted cache.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  arb_busy,
    output logic                  grant_i,
    output logic                  grant_d
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    arb_state_t            state_r, state_nxt_s;
    owner_t                owner_r, last_grant_r, win_s;
    logic                  write_r;
    logic                  i_req_s, d_req_s, grant_s, win_write_s, burst_done_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [LINE_WIDTH-1:0] line_next_s;

    logic                  mem_read_nxt_s, mem_write_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_address_nxt_s;
    logic                  grant_i_nxt_s, grant_d_nxt_s, busy_nxt_s;
    logic                  iresp_nxt_s, dresp_nxt_s;
    logic [LINE_WIDTH-1:0] irdata_nxt_s, drdata_nxt_s;

    assign i_req_s     = icache_pmem_read;
    assign d_req_s     = dcache_pmem_read || dcache_pmem_write;
    assign grant_s     = (state_r == IDLE) && (i_req_s || d_req_s);
    assign win_s       = pick_winner(i_req_s, d_req_s, last_grant_r);
    assign win_write_s = (win_s == DCACHE) && dcache_pmem_write;
    assign win_addr_s  = ((win_s == DCACHE) ? dcache_pmem_address : icache_pmem_address)
                         & ALIGN_MASK;

    line_burst_adaptor #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_adaptor (
        .clk         (clk),
        .rst         (rst),
        .start       (grant_s),
        .start_write (win_write_s),
        .start_line  (dcache_pmem_wdata),
        .active      (state_r == BURST),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .line_next   (line_next_s),
        .mem_wdata   (mem_wdata),
        .burst_done  (burst_done_s)
    );

    cache_mem_arbiter_checker u_checker (
        .clk               (clk),
        .rst               (rst),
        .dcache_pmem_read  (dcache_pmem_read),
        .dcache_pmem_write (dcache_pmem_write),
        .grant_i           (grant_i),
        .grant_d           (grant_d),
        .icache_pmem_resp  (icache_pmem_resp),
        .dcache_pmem_resp  (dcache_pmem_resp)
    );

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= IDLE;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_address       <= {ADDR_WIDTH{1'b0}};
            grant_i           <= 1'b0;
            grant_d           <= 1'b0;
            arb_busy          <= 1'b0;
            icache_pmem_resp  <= 1'b0;
            dcache_pmem_resp  <= 1'b0;
            icache_pmem_rdata <= {LINE_WIDTH{1'b0}};
            dcache_pmem_rdata <= {LINE_WIDTH{1'b0}};
        end else begin
            state_r           <= state_nxt_s;
            mem_read          <= mem_read_nxt_s;
            mem_write         <= mem_write_nxt_s;
            mem_address       <= mem_address_nxt_s;
            grant_i           <= grant_i_nxt_s;
            grant_d           <= grant_d_nxt_s;
            arb_busy          <= busy_nxt_s;
            icache_pmem_resp  <= iresp_nxt_s;
            dcache_pmem_resp  <= dresp_nxt_s;
            icache_pmem_rdata <= irdata_nxt_s;
            dcache_pmem_rdata <= drdata_nxt_s;
        end
    end

    // Burst ownership and fairness history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r      <= ICACHE;
            write_r      <= 1'b0;
            last_grant_r <= ICACHE;
        end else if (grant_s) begin
            owner_r <= win_s;
            write_r <= win_write_s;
        end else if (burst_done_s) begin
            last_grant_r <= owner_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = grant_s ? BURST : IDLE;
            BURST:   state_nxt_s = burst_done_s ? DONE : BURST;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        mem_read_nxt_s    = mem_read;
        mem_write_nxt_s   = mem_write;
        mem_address_nxt_s = mem_address;
        grant_i_nxt_s     = grant_i;
        grant_d_nxt_s     = grant_d;
        busy_nxt_s        = arb_busy;
        iresp_nxt_s       = 1'b0;
        dresp_nxt_s       = 1'b0;
        irdata_nxt_s      = icache_pmem_rdata;
        drdata_nxt_s      = dcache_pmem_rdata;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    mem_read_nxt_s    = !win_write_s;
                    mem_write_nxt_s   = win_write_s;
                    mem_address_nxt_s = win_addr_s;
                    grant_i_nxt_s     = (win_s == ICACHE);
                    grant_d_nxt_s     = (win_s == DCACHE);
                    busy_nxt_s        = 1'b1;
                end else begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    grant_i_nxt_s   = 1'b0;
                    grant_d_nxt_s   = 1'b0;
                    busy_nxt_s      = 1'b0;
                end
            end
            BURST: begin
                if (burst_done_s) begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    if (owner_r == ICACHE) begin
                        iresp_nxt_s  = 1'b1;
                        irdata_nxt_s = line_next_s;
                    end else begin
                        dresp_nxt_s  = 1'b1;
                        drdata_nxt_s = write_r ? dcache_pmem_rdata : line_next_s;
                    end
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            DONE: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
                grant_i_nxt_s   = 1'b0;
                grant_d_nxt_s   = 1'b0;
                busy_nxt_s      = 1'b0;
            end
            default: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
                grant_i_nxt_s   = 1'b0;
                grant_d_nxt_s   = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fills, writeback, arbitration order,
// mem_resp gaps, asynchronous reset mid-burst and requests raised mid-burst.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_pmem_read;
    logic [31:0]  icache_pmem_address;
    logic [255:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [31:0]  dcache_pmem_address;
    logic [255:0] dcache_pmem_wdata;
    logic [255:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;
    logic         arb_busy;
    logic         grant_i;
    logic         grant_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_address         (mem_address),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_resp            (mem_resp),
        .arb_busy            (arb_busy),
        .grant_i             (grant_i),
        .grant_d             (grant_d)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Four back-to-back beats; ends 1 ns after the edge that takes the last beat.
    task automatic serve(input logic [255:0] line);
        for (int k = 0; k < 4; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = line[64*k +: 64];
            tick();
            if (k < 3) chk("early_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
        end
        mem_resp  = 1'b0;
        mem_rdata = 64'h0;
    endtask

    initial begin
        logic [255:0] li, ld, lg, lw, la, lb, lr, lx, ly, lz;
        logic [6:0]   pat;
        int           k;
        li = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        ld = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
              64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        lg = {64'h6363_6363_0000_0003, 64'h6262_6262_0000_0002,
              64'h6161_6161_0000_0001, 64'h6060_6060_0000_0000};
        lw = {64'hBBBB_0003_CAFE_0003, 64'hBBBB_0002_CAFE_0002,
              64'hBBBB_0001_CAFE_0001, 64'hBBBB_0000_CAFE_0000};
        la = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
        lb = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
              64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
        lr = {64'h0000_0000_0000_0DDD, 64'h0000_0000_0000_0CCC,
              64'h0000_0000_0000_0BBB, 64'h0000_0000_0000_0AAA};
        lx = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
              64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        ly = {64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0003,
              64'h5A5A_0000_0000_0002, 64'h5A5A_0000_0000_0001};
        lz = {64'hC3C3_0000_0000_0004, 64'hC3C3_0000_0000_0003,
              64'hC3C3_0000_0000_0002, 64'hC3C3_0000_0000_0001};

        rst                 = 1'b0;
        icache_pmem_read    = 1'b0;
        icache_pmem_address = 32'h0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = 32'h0;
        dcache_pmem_wdata   = 256'h0;
        mem_rdata           = 64'h0;
        mem_resp            = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        chk("rst_grant_busy", {grant_i, grant_d, arb_busy}, 3'b000);
        chk("rst_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
        chk("rst_irdata", icache_pmem_rdata, 256'h0);
        chk("rst_drdata", dcache_pmem_rdata, 256'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        rst = 1'b1;
        tick();

        // Icache fill at 0x44
        icache_pmem_address = 32'h0000_0044;
        icache_pmem_read    = 1'b1;
        tick();
        chk("i_mem_rw", {mem_read, mem_write}, 2'b10);
        chk("i_addr", mem_address, 32'h0000_0040);
        chk("i_grant", {grant_i, grant_d, arb_busy}, 3'b101);
        serve(li);
        chk("i_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b10);
        chk("i_rdata", icache_pmem_rdata, li);
        chk("i_mem_drop", {mem_read, arb_busy}, 2'b01);
        icache_pmem_read = 1'b0;
        tick();
        chk("i_idle", {icache_pmem_resp, grant_i, grant_d, arb_busy}, 4'b0000);
        chk("i_rdata_hold", icache_pmem_rdata, li);

        // Simultaneous requests with last_grant=ICACHE: dcache first
        icache_pmem_address = 32'h0000_0100;
        icache_pmem_read    = 1'b1;
        dcache_pmem_address = 32'h0000_0200;
        dcache_pmem_read    = 1'b1;
        tick();
        chk("tie1_grant_d", {grant_i, grant_d}, 2'b01);
        chk("tie1_addr_d", mem_address, 32'h0000_0200);
        serve(ld);
        chk("tie1_d_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b01);
        chk("tie1_d_rdata", dcache_pmem_rdata, ld);
        dcache_pmem_read = 1'b0;
        tick();
        chk("tie1_gap", {grant_i, grant_d, mem_read}, 3'b000);
        tick();
        chk("tie1_grant_i", {grant_i, grant_d, mem_read}, 3'b101);
        chk("tie1_addr_i", mem_address, 32'h0000_0100);
        serve(lg);
        chk("tie1_i_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b10);
        chk("tie1_i_rdata", icache_pmem_rdata, lg);
        icache_pmem_read = 1'b0;
        tick();

        // Dcache writeback at 0x1234_5678
        dcache_pmem_address = 32'h1234_5678;
        dcache_pmem_wdata   = lw;
        dcache_pmem_write   = 1'b1;
        tick();
        chk("w_mem_rw", {mem_read, mem_write, grant_d}, 3'b011);
        chk("w_addr", mem_address, 32'h1234_5660);
        chk("w_beat0", mem_wdata, 64'hBBBB_0000_CAFE_0000);
        mem_resp = 1'b1;
        tick();
        chk("w_beat1", mem_wdata, 64'hBBBB_0001_CAFE_0001);
        tick();
        chk("w_beat2", mem_wdata, 64'hBBBB_0002_CAFE_0002);
        tick();
        chk("w_beat3", mem_wdata, 64'hBBBB_0003_CAFE_0003);
        chk("w_no_early", dcache_pmem_resp, 1'b0);
        tick();
        mem_resp = 1'b0;
        chk("w_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b01);
        chk("w_mem_drop", {mem_read, mem_write}, 2'b00);
        chk("w_drdata_hold", dcache_pmem_rdata, ld);
        dcache_pmem_write = 1'b0;
        tick();

        // Simultaneous requests with last_grant=DCACHE: icache first
        icache_pmem_address = 32'h0000_0180;
        icache_pmem_read    = 1'b1;
        dcache_pmem_address = 32'h0000_0280;
        dcache_pmem_read    = 1'b1;
        tick();
        chk("tie2_grant_i", {grant_i, grant_d}, 2'b10);
        chk("tie2_addr_i", mem_address, 32'h0000_0180);
        serve(la);
        chk("tie2_i_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b10);
        chk("tie2_i_rdata", icache_pmem_rdata, la);
        icache_pmem_read = 1'b0;
        tick();
        tick();
        chk("tie2_grant_d", {grant_i, grant_d, mem_read}, 3'b011);
        chk("tie2_addr_d", mem_address, 32'h0000_0280);
        serve(lb);
        chk("tie2_d_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b01);
        chk("tie2_d_rdata", dcache_pmem_rdata, lb);
        dcache_pmem_read = 1'b0;
        tick();

        // Read burst with mem_resp gaps 1,0,0,1,1,0,1
        icache_pmem_address = 32'h0000_0084;
        icache_pmem_read    = 1'b1;
        tick();
        chk("gap_addr", mem_address, 32'h0000_0080);
        pat = 7'b1011001;
        k   = 0;
        for (int i = 0; i < 7; i++) begin
            mem_resp  = pat[i];
            mem_rdata = pat[i] ? lr[64*k +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i]) k++;
            tick();
            if (i == 5) begin
                chk("gap_no_early", icache_pmem_resp, 1'b0);
                chk("gap_read_held", {mem_read, mem_address}, {1'b1, 32'h0000_0080});
            end
        end
        mem_resp = 1'b0;
        chk("gap_resp", icache_pmem_resp, 1'b1);
        chk("gap_rdata", icache_pmem_rdata, lr);
        icache_pmem_read = 1'b0;
        tick();

        // Asynchronous reset after two beats of a dcache read
        dcache_pmem_address = 32'h0000_030C;
        dcache_pmem_read    = 1'b1;
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 64'hEEEE_EEEE_EEEE_0000;
        tick();
        mem_rdata = 64'hEEEE_EEEE_EEEE_0001;
        tick();
        mem_resp = 1'b0;
        rst      = 1'b0;
        #1;
        chk("arst_outputs", {mem_read, grant_d, arb_busy, dcache_pmem_resp}, 4'b0000);
        chk("arst_irdata", icache_pmem_rdata, 256'h0);
        chk("arst_drdata", dcache_pmem_rdata, 256'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_restart", {mem_read, grant_d, arb_busy}, 3'b111);
        chk("arst_addr", mem_address, 32'h0000_0300);
        serve(lx);
        chk("arst_resp", dcache_pmem_resp, 1'b1);
        chk("arst_rdata", dcache_pmem_rdata, lx);
        dcache_pmem_read = 1'b0;
        tick();

        // Icache request raised in the middle of a dcache burst
        dcache_pmem_address = 32'h0000_0400;
        dcache_pmem_read    = 1'b1;
        tick();
        mem_resp  = 1'b1;
        mem_rdata = ly[63:0];
        tick();
        icache_pmem_address = 32'h0000_0500;
        icache_pmem_read    = 1'b1;
        mem_rdata           = ly[127:64];
        tick();
        chk("mid_hold1", {mem_read, grant_i, grant_d, mem_address}, {3'b101, 32'h0000_0400});
        mem_rdata = ly[191:128];
        tick();
        chk("mid_hold2", {mem_read, grant_i, grant_d, mem_address}, {3'b101, 32'h0000_0400});
        mem_rdata = ly[255:192];
        tick();
        mem_resp = 1'b0;
        chk("mid_d_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b01);
        chk("mid_d_rdata", dcache_pmem_rdata, ly);
        dcache_pmem_read = 1'b0;
        tick();
        chk("mid_idle", {mem_read, grant_i}, 2'b00);
        tick();
        chk("mid_i_start", {mem_read, grant_i}, 2'b11);
        chk("mid_i_addr", mem_address, 32'h0000_0500);
        serve(lz);
        chk("mid_i_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b10);
        chk("mid_i_rdata", icache_pmem_rdata, lz);
        icache_pmem_read = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
